// File: rtl/misc_pkg.sv
// Shared scalar word types used across the block.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package misc_pkg;

    typedef logic [31:0] U32;
    typedef logic [63:0] U64;

endpackage : misc_pkg

// File: rtl/msix_pkg.sv
// MSI-X generator encodings: FSM states and table field selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a (types and constants only).
package msix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } msix_state_e;

    typedef enum logic [1:0] {
        CFG_ADDR_LO = 2'd0,
        CFG_ADDR_HI = 2'd1,
        CFG_DATA    = 2'd2,
        CFG_CTRL    = 2'd3
    } msix_cfg_sel_e;

    // Bit of the ctrl word that holds the per-vector mask.
    localparam int CTRL_MASK_BIT = 0;

endpackage : msix_pkg

// File: rtl/msix_rr_arb.sv
// Round-robin picker: first set request at or after i_ptr, wrapping at NUM_VEC.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when to consume the grant.
//
// Ports:
//   i_req     request vector, one bit per vector
//   i_ptr     index searched first
//   o_gnt_idx granted vector index (0 when o_gnt_vld is low)
//   o_gnt_vld at least one request is set
module msix_rr_arb #(
    parameter  int NUM_VEC = 8,
    localparam int IDXW    = $clog2(NUM_VEC)
) (
    input  logic [NUM_VEC-1:0] i_req,
    input  logic [IDXW-1:0]    i_ptr,
    output logic [IDXW-1:0]    o_gnt_idx,
    output logic               o_gnt_vld
);

    // Walk from the farthest distance down to zero so that the closest
    // request to the pointer is the last assignment and therefore wins.
    always_comb begin
        int w_idx;
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        for (int k = NUM_VEC - 1; k >= 0; k--) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NUM_VEC) begin
                w_idx = w_idx - NUM_VEC;
            end
            if (i_req[w_idx]) begin
                o_gnt_idx = IDXW'(w_idx);
                o_gnt_vld = 1'b1;
            end
        end
    end

endmodule : msix_rr_arb

// File: rtl/msix_intr_gen.sv
// MSI-X interrupt generator: per-vector addr/data/mask table, pending bits, one DW host write per message.
// Latency: 1 cycle from a visible unmasked pending bit to wr_valid; next pick after wr_done.
// Backpressure: wr_valid/wr_addr/wr_data held stable until wr_ready; one message in flight until wr_done.
//
// Ports:
//   clk, rst_n          sole clock, async active-low reset
//   func_mask           function-level mask of all vectors (only with MSIX_FUNC_MASK_EN defined)
//   intr_req            per-vector one-cycle request pulses
//   cfg_we/idx/sel/wdata table write port (sel: addr_lo, addr_hi, data, ctrl[0]=mask)
//   wr_valid/ready      host write request handshake, wr_addr/wr_data message payload
//   wr_done             host write completion pulse
//   pend, busy          pending bit array, FSM not idle
module msix_intr_gen #(
    parameter  int NUM_VEC = 8,
    localparam int IDXW    = $clog2(NUM_VEC)
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef MSIX_FUNC_MASK_EN
    input  logic               func_mask,
`endif
    input  logic [NUM_VEC-1:0] intr_req,
    input  logic               cfg_we,
    input  logic [IDXW-1:0]    cfg_idx,
    input  logic [1:0]         cfg_sel,
    input  logic [31:0]        cfg_wdata,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [63:0]        wr_addr,
    output logic [31:0]        wr_data,
    input  logic               wr_done,
    output logic [NUM_VEC-1:0] pend,
    output logic               busy
);

    import misc_pkg::*;
    import msix_pkg::*;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_VEC - 1);
    localparam logic [IDXW:0]   VEC_CNT  = (IDXW + 1)'(NUM_VEC);

    U64                 r_tbl_addr [NUM_VEC];
    U32                 r_tbl_data [NUM_VEC];
    logic [NUM_VEC-1:0] r_mask;
    logic [NUM_VEC-1:0] r_pend;
    logic [IDXW-1:0]    r_rr_ptr;
    logic [IDXW-1:0]    r_cur_idx;
    U64                 r_wr_addr;
    U32                 r_wr_data;
    msix_state_e        r_state;

    msix_state_e        w_state_nxt;
    logic               w_func_mask;
    logic               w_cfg_idx_ok;
    logic [NUM_VEC-1:0] w_elig;
    logic [NUM_VEC-1:0] w_clr;
    logic [IDXW-1:0]    w_gnt_idx;
    logic               w_gnt_vld;
    logic               w_load;
    logic               w_hs;

`ifdef MSIX_FUNC_MASK_EN
    assign w_func_mask = func_mask;
`else
    assign w_func_mask = 1'b0;
`endif

    // Non-power-of-two NUM_VEC leaves unused index codes; writes to them are dropped.
    assign w_cfg_idx_ok = ({1'b0, cfg_idx} < VEC_CNT);

    // Mask only gates the pick in IDLE; once a message is latched it goes out regardless.
    assign w_elig = r_pend & ~r_mask & ~{NUM_VEC{w_func_mask}};

    msix_rr_arb #(
        .NUM_VEC (NUM_VEC)
    ) u_arb (
        .i_req     (w_elig),
        .i_ptr     (r_rr_ptr),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    // ---------------- vector table ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VEC; i++) begin
                r_tbl_addr[i] <= '0;
                r_tbl_data[i] <= '0;
            end
            r_mask <= '1;
        end else if (cfg_we && w_cfg_idx_ok) begin
            case (msix_cfg_sel_e'(cfg_sel))
                CFG_ADDR_LO: r_tbl_addr[cfg_idx][31:0]  <= cfg_wdata;
                CFG_ADDR_HI: r_tbl_addr[cfg_idx][63:32] <= cfg_wdata;
                CFG_DATA:    r_tbl_data[cfg_idx]        <= cfg_wdata;
                CFG_CTRL:    r_mask[cfg_idx]            <= cfg_wdata[CTRL_MASK_BIT];
                default:     ;
            endcase
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_hs        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_vld) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (wr_ready) begin
                    w_hs        = 1'b1;
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (wr_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- message registers and round-robin pointer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_cur_idx <= '0;
            r_rr_ptr  <= '0;
        end else begin
            // Payload is copied out of the table here, so later table writes
            // to the same vector cannot disturb a message already in flight.
            if (w_load) begin
                r_wr_addr <= r_tbl_addr[w_gnt_idx];
                r_wr_data <= r_tbl_data[w_gnt_idx];
                r_cur_idx <= w_gnt_idx;
            end
            if (w_hs) begin
                r_rr_ptr <= (r_cur_idx == LAST_IDX) ? '0 : r_cur_idx + IDXW'(1);
            end
        end
    end

    // ---------------- pending bits ----------------
    // A request arriving on the same edge as the clear wins, so it is not lost.
    assign w_clr = {{(NUM_VEC-1){1'b0}}, w_hs} << r_cur_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | intr_req;
        end
    end

    assign wr_valid = (r_state == ST_SEND);
    assign busy     = (r_state != ST_IDLE);
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign pend     = r_pend;

endmodule : msix_intr_gen

// File: tb/tb_msix_intr_gen.sv
// Self-checking bench for msix_intr_gen with an abstract per-vector model.
// Latency: model predicts wr_valid one edge after a visible eligible pending bit.
// Backpressure: host model drives wr_ready (fixed, random or stalled) and delayed wr_done.
module tb_msix_intr_gen;

    localparam int N  = 8;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  intr_req;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [1:0]    cfg_sel;
    logic [31:0]   cfg_wdata;
    logic          wr_valid;
    logic          wr_ready;
    logic [63:0]   wr_addr;
    logic [31:0]   wr_data;
    logic          wr_done;
    logic [N-1:0]  pend;
    logic          busy;

    always #5 clk = ~clk;

    msix_intr_gen #(.NUM_VEC(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .intr_req  (intr_req),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_sel   (cfg_sel),
        .cfg_wdata (cfg_wdata),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_done   (wr_done),
        .pend      (pend),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: table, pending set, pointer and message phase (0 idle, 1 offered, 2 awaiting done).
    bit [63:0] m_addr [N];
    bit [31:0] m_data [N];
    bit [N-1:0] m_mask, m_pend;
    int        m_ptr, m_cur, m_phase, m_sent;
    bit [63:0] m_exp_addr;
    bit [31:0] m_exp_data;

    // Host model
    int        rdy_mode;      // 0: ready, 1: random, 2: stalled
    bit        hold_done, spurious_en, host_outst;
    int        host_timer;
    bit [63:0] log_addr [$];
    bit [31:0] log_data [$];

    function automatic int rr_pick(bit [N-1:0] e, int p);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (e[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_addr[i] = '0;
            m_data[i] = '0;
        end
        m_mask = '1; m_pend = '0; m_ptr = 0; m_cur = 0; m_phase = 0;
        host_outst = 1'b0; host_timer = 0;
    endtask

    // One clock: drive host, advance model, step DUT, compare.
    task automatic cycle();
        bit [N-1:0] elig;
        bit         hs;
        bit [63:0]  pre_addr;
        bit [31:0]  pre_data;
        int         v;
        case (rdy_mode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = 1'($urandom_range(0, 1));
            default: wr_ready = 1'b0;
        endcase
        wr_done = 1'b0;
        if (host_outst) begin
            if (host_timer == 0 && !hold_done) wr_done = 1'b1;
        end else if (spurious_en && $urandom_range(0, 7) == 0) begin
            wr_done = 1'b1;
        end
        hs       = wr_valid && wr_ready;
        pre_addr = wr_addr;
        pre_data = wr_data;

        elig = m_pend & ~m_mask;
        case (m_phase)
            0: if (elig != 0) begin
                v = rr_pick(elig, m_ptr);
                m_cur = v; m_exp_addr = m_addr[v]; m_exp_data = m_data[v]; m_phase = 1;
            end
            1: if (wr_ready) begin
                m_pend[m_cur] = 1'b0; m_ptr = (m_cur + 1) % N; m_phase = 2; m_sent++;
            end
            default: if (wr_done) m_phase = 0;
        endcase
        m_pend |= intr_req;
        if (cfg_we) begin
            case (cfg_sel)
                2'd0:    m_addr[cfg_idx][31:0]  = cfg_wdata;
                2'd1:    m_addr[cfg_idx][63:32] = cfg_wdata;
                2'd2:    m_data[cfg_idx]        = cfg_wdata;
                default: m_mask[cfg_idx]        = cfg_wdata[0];
            endcase
        end

        @(posedge clk);
        #1;

        if (hs) begin
            $display("host: MSIX triggered addr=%h data=%h", pre_addr, pre_data);
            log_addr.push_back(pre_addr);
            log_data.push_back(pre_data);
            host_outst = 1'b1;
            host_timer = $urandom_range(0, 2);
        end else if (host_outst) begin
            if (wr_done) host_outst = 1'b0;
            else if (host_timer > 0) host_timer--;
        end
        intr_req = '0;
        cfg_we   = 1'b0;

        checks++;
        if ({wr_valid, busy, pend} !== {m_phase == 1, m_phase != 0, m_pend}) begin
            errors++;
            $display("FAIL cycle_ctrl t=%0t got valid=%b busy=%b pend=%b want valid=%b busy=%b pend=%b",
                     $time, wr_valid, busy, pend, m_phase == 1, m_phase != 0, m_pend);
        end
        if (m_phase == 1) begin
            checks++;
            if (wr_addr !== m_exp_addr) begin
                errors++;
                $display("FAIL cycle_addr t=%0t got %h want %h", $time, wr_addr, m_exp_addr);
            end
            checks++;
            if (wr_data !== m_exp_data) begin
                errors++;
                $display("FAIL cycle_data t=%0t got %h want %h", $time, wr_data, m_exp_data);
            end
        end
    endtask

    task automatic cfg_wr(int idx, int sel, bit [31:0] d);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_sel = 2'(sel); cfg_wdata = d;
        cycle();
    endtask

    task automatic prog_vec(int idx, bit [63:0] a, bit [31:0] d, bit msk);
        cfg_wr(idx, 0, a[31:0]);
        cfg_wr(idx, 1, a[63:32]);
        cfg_wr(idx, 2, d);
        cfg_wr(idx, 3, {31'd0, msk});
    endtask

    task automatic run_until_idle(int max);
        int k = 0;
        while ((m_phase != 0 || (m_pend & ~m_mask) != 0) && k < max) begin
            cycle();
            k++;
        end
        checks++;
        if (k >= max) begin
            errors++;
            $display("FAIL drain_timeout got %0d cycles want < %0d", k, max);
        end
    endtask

    task automatic wait_valid(string nm);
        int k = 0;
        while (wr_valid !== 1'b1 && k < 10) begin
            cycle();
            k++;
        end
        checks++;
        if (wr_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid_timeout got %b want 1", nm, wr_valid);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        checks++;
        if ({wr_valid, busy, pend, wr_addr, wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b busy=%b pend=%h addr=%h data=%h want all 0",
                     wr_valid, busy, pend, wr_addr, wr_data);
        end
        rst_n = 1'b1;
        model_reset();
        // All vectors come out of reset masked: requests pend but nothing is sent.
        intr_req = '1;
        repeat (6) cycle();
        checks++;
        if (log_addr.size() != 0) begin
            errors++;
            $display("FAIL reset_masked got %0d writes want 0", log_addr.size());
        end
        apply_reset();
    endtask

    task automatic test_single();
        int n0 = log_addr.size();
        prog_vec(0, 64'h1, 32'h1234_5678, 1'b0);
        intr_req[0] = 1'b1;
        cycle();
        checks++;
        if (wr_valid !== 1'b0 || pend[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_pend got valid=%b pend0=%b want 0 1", wr_valid, pend[0]);
        end
        cycle();
        checks++;
        if (wr_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency got valid=%b want 1", wr_valid);
        end
        run_until_idle(50);
        checks++;
        if (log_addr.size() != n0 + 1) begin
            errors++;
            $display("FAIL single_count got %0d want %0d", log_addr.size() - n0, 1);
        end else begin
            checks++;
            if (log_addr[n0] !== 64'h1 || log_data[n0] !== 32'h1234_5678) begin
                errors++;
                $display("FAIL single_msg got %h/%h want 1/12345678", log_addr[n0], log_data[n0]);
            end
        end
    endtask

    task automatic test_two_vec();
        int n0;
        prog_vec(2, 64'h0000_0001_2345_0002, 32'h2222_0002, 1'b0);
        prog_vec(5, 64'hFFFF_FFFF_FFFF_FFF5, 32'h5555_0005, 1'b0);
        n0 = log_addr.size();
        intr_req[2] = 1'b1;
        intr_req[5] = 1'b1;
        cycle();
        run_until_idle(100);
        checks++;
        if (log_addr.size() != n0 + 2) begin
            errors++;
            $display("FAIL two_count got %0d want 2", log_addr.size() - n0);
        end else begin
            checks++;
            if (log_addr[n0] !== 64'h0000_0001_2345_0002 || log_addr[n0+1] !== 64'hFFFF_FFFF_FFFF_FFF5) begin
                errors++;
                $display("FAIL two_order got %h,%h want vec2 then vec5", log_addr[n0], log_addr[n0+1]);
            end
        end
        checks++;
        if (pend !== '0) begin
            errors++;
            $display("FAIL two_pend got %b want 0", pend);
        end
    endtask

    task automatic test_mask();
        int n0;
        prog_vec(3, 64'h3000_0003, 32'h3333_0003, 1'b1);
        n0 = log_addr.size();
        intr_req[3] = 1'b1;
        cycle();
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (wr_valid !== 1'b0) begin
                errors++;
                $display("FAIL mask_hold got valid=%b want 0", wr_valid);
            end
        end
        checks++;
        if (pend[3] !== 1'b1) begin
            errors++;
            $display("FAIL mask_pend got %b want 1", pend[3]);
        end
        cfg_wr(3, 3, 32'd0);
        run_until_idle(50);
        checks++;
        if (log_addr.size() != n0 + 1 || log_addr[$] !== 64'h3000_0003 || log_data[$] !== 32'h3333_0003) begin
            errors++;
            $display("FAIL mask_release got %0d writes last %h want 1 write 3000_0003", log_addr.size() - n0,
                     log_addr.size() > 0 ? log_addr[$] : 64'd0);
        end
    endtask

    task automatic test_backpressure();
        prog_vec(4, 64'h4444_0000_0000_0044, 32'hB0B0_4444, 1'b0);
        rdy_mode = 2;
        intr_req[4] = 1'b1;
        cycle();
        wait_valid("bp");
        cfg_wr(4, 2, 32'h0000_DEAD);
        for (int i = 0; i < 4; i++) cycle();
        checks++;
        if (wr_data !== 32'hB0B0_4444 || wr_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stable got valid=%b data=%h want 1 b0b04444", wr_valid, wr_data);
        end
        rdy_mode = 0;
        run_until_idle(50);
        checks++;
        if (log_data[$] !== 32'hB0B0_4444) begin
            errors++;
            $display("FAIL bp_sent got %h want b0b04444", log_data[$]);
        end
        intr_req[4] = 1'b1;
        cycle();
        run_until_idle(50);
        checks++;
        if (log_data[$] !== 32'h0000_DEAD) begin
            errors++;
            $display("FAIL bp_newdata got %h want 0000dead", log_data[$]);
        end
    endtask

    task automatic test_req_at_handshake();
        int n0;
        prog_vec(1, 64'h1000, 32'h1111_0001, 1'b0);
        n0 = log_addr.size();
        rdy_mode = 2;
        intr_req[1] = 1'b1;
        cycle();
        wait_valid("rah");
        rdy_mode = 0;
        intr_req[1] = 1'b1;
        cycle();
        checks++;
        if (pend[1] !== 1'b1) begin
            errors++;
            $display("FAIL rah_pend got %b want 1", pend[1]);
        end
        run_until_idle(50);
        checks++;
        if (log_addr.size() != n0 + 2 || log_addr[$] !== 64'h1000) begin
            errors++;
            $display("FAIL rah_count got %0d writes want 2 from vec1", log_addr.size() - n0);
        end
    endtask

    task automatic test_reset_midflight();
        int n0, k;
        prog_vec(6, 64'h6000, 32'h6666_0006, 1'b0);
        hold_done = 1'b1;
        intr_req[6] = 1'b1;
        intr_req[7] = 1'b1;
        cycle();
        k = 0;
        while (!host_outst && k < 10) begin
            cycle();
            k++;
        end
        cycle();
        checks++;
        if (busy !== 1'b1 || pend[7] !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup got busy=%b pend7=%b want 1 1", busy, pend[7]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || pend !== '0 || wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b pend=%b valid=%b want 0 0 0", busy, pend, wr_valid);
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        hold_done = 1'b0;
        n0 = log_addr.size();
        intr_req[6] = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        checks++;
        if (log_addr.size() != n0 || pend[6] !== 1'b1) begin
            errors++;
            $display("FAIL mid_after got %0d writes pend6=%b want 0 writes pend6=1", log_addr.size() - n0, pend[6]);
        end
        apply_reset();
    endtask

    task automatic test_random();
        int n0, s0;
        rdy_mode = 1;
        spurious_en = 1'b1;
        for (int i = 0; i < N; i++) prog_vec(i, {$urandom, $urandom}, $urandom, 1'($urandom_range(0, 1)));
        n0 = log_addr.size();
        s0 = m_sent;
        for (int c = 0; c < 300; c++) begin
            intr_req = N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 9) == 0) begin
                cfg_we = 1'b1; cfg_idx = IW'($urandom_range(0, N - 1));
                cfg_sel = 2'($urandom_range(0, 3)); cfg_wdata = $urandom;
            end
            cycle();
        end
        for (int i = 0; i < N; i++) cfg_wr(i, 3, 32'd0);
        run_until_idle(400);
        checks++;
        if (pend !== '0) begin
            errors++;
            $display("FAIL rand_drain got pend=%b want 0", pend);
        end
        checks++;
        if (log_addr.size() - n0 != m_sent - s0) begin
            errors++;
            $display("FAIL rand_count got %0d writes want %0d", log_addr.size() - n0, m_sent - s0);
        end
        rdy_mode = 0;
        spurious_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; intr_req = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_wdata = '0;
        wr_ready = 1'b0; wr_done = 1'b0;
        rdy_mode = 0; hold_done = 1'b0; spurious_en = 1'b0; m_sent = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_two_vec();
        test_mask();
        test_backpressure();
        test_req_at_handshake();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_msix_intr_gen

// File: doc/msix_intr_gen.md
MSIX_INTR_GEN -- requirements
Module: msix_intr_gen

Interface
REQ-001 SHALL have parameter NUM_VEC, default 8, number of MSI-X vectors (2..32).
REQ-002 SHALL have derived localparam IDXW, value $clog2(NUM_VEC), giving the vector index width.
REQ-003 SHALL use one clock and an asynchronous active-low reset, with ports listed first:
- clk  in  1  sole clock.
- rst_n  in  1  async reset, active low.
REQ-004 SHALL have the following remaining ports:
- intr_req  in  NUM_VEC  per-vector one-cycle interrupt request pulses.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  IDXW  table entry index.
- cfg_sel  in  2  field select: 0 addr_lo, 1 addr_hi, 2 data, 3 ctrl (bit0 = mask).
- cfg_wdata  in  32  table write data.
- wr_valid  out  1  host DW write request valid.
- wr_ready  in  1  host accepts request.
- wr_addr  out  64  message address.
- wr_data  out  32  message data.
- wr_done  in  1  one-cycle pulse marking host write completion.
- pend  out  NUM_VEC  pending bit array.
- busy  out  1  high whenever FSM is not IDLE.

Function
REQ-005 SHALL hold a per-vector table of addr (64 bits), data (32 bits) and mask (1 bit), written on cfg_we at the next clk edge.
REQ-006 SHALL set pend[i] at the clk edge where intr_req[i]=1, regardless of mask.
REQ-007 SHALL use FSM states IDLE, SEND and WAIT_DONE.
REQ-008 IDLE: if any pend[i]&~mask[i] is set, SHALL pick the vector by round-robin, starting at the index after the last vector served.
REQ-009 On that pick, SHALL latch the vector's addr and data into the output registers and go to SEND, with wr_valid=1 on the next cycle (1-cycle latency from pending to valid).
REQ-010 SEND: wr_valid, wr_addr and wr_data SHALL stay stable until wr_valid&wr_ready.
REQ-011 On the SEND handshake, SHALL clear pend of the sent vector, update the round-robin pointer and go to WAIT_DONE with wr_valid=0.
REQ-012 WAIT_DONE: SHALL return to IDLE on wr_done; wr_done in any other state SHALL be ignored.
REQ-013 If intr_req[i] arrives in the same cycle pend[i] is cleared, pend[i] SHALL remain 1.
REQ-014 A table write to the vector in flight SHALL NOT alter wr_addr or wr_data of the current message.
REQ-015 A masked vector SHALL keep pend set and SHALL be sent once unmasked.
REQ-016 Setting a vector's mask while it is in SEND SHALL NOT withdraw the request.
REQ-017 wr_addr SHALL be sent unmodified, with no alignment forcing.
REQ-018 Multiple intr_req pulses on one vector before it is sent SHALL produce exactly one message.

Reset
REQ-019 On rst_n low, SHALL asynchronously set: state IDLE, wr_valid 0, wr_addr 0, wr_data 0, pend 0, busy 0, round-robin pointer 0.
REQ-020 On rst_n low, SHALL set every table addr and data to 0 and every mask to 1.
REQ-021 Reset during SEND or WAIT_DONE SHALL drop the message with no further wr_valid.

Configuration
REQ-022 With MSIX_FUNC_MASK_EN defined, SHALL add input port func_mask (1 bit), treated as masking all vectors per REQ-008/REQ-015.
REQ-023 With MSIX_FUNC_MASK_EN undefined, the func_mask port SHALL be absent and behaviour SHALL equal func_mask=0.

Structure
REQ-024 FSM state enum and cfg_sel encodings SHALL live in msix_pkg; U32/U64 types SHALL come from misc_pkg.
REQ-025 Round-robin selection SHALL be a sub-module msix_rr_arb (inputs: request vector and pointer; outputs: grant index and grant valid).

Verification
REQ-026 Program vector 0 with addr 0x1 and data 0x12345678, unmask, pulse intr_req[0]; wr_ready tied 1 -> one write with addr 0x1 and data 0x12345678; host model reports MSIX triggered.
REQ-027 Pulse intr_req[2] and intr_req[5] in the same cycle, all unmasked -> vector 2 is sent, then vector 5; two writes total; pend returns to 0.
REQ-028 Vector 3 masked, pulse intr_req[3] -> pend[3]=1 and no wr_valid for 20 cycles; unmask -> one write with vector 3 addr/data.
REQ-029 Hold wr_ready=0 for 5 cycles while rewriting the in-flight vector's data to 0xDEAD -> wr_data is stable at the old value through the handshake.
REQ-030 Pulse intr_req[1] in the same cycle as vector 1's handshake -> a second vector-1 write follows after wr_done.
REQ-031 Assert rst_n low during WAIT_DONE -> busy=0, pend=0 and all masks=1 immediately; no write after release.
